rf_access_ctrl: RTL and testbench

Initiator-side sequencer for the 32x32 dual-read register file. It converts single-cycle host requests (operand fetch, writeback) into the file's READ/WRITE protocol, with correct READ/WRITE encoding and hold times. It captures both read ports into stable operand registers. It sits between the datapath control and the register file, sharing CLK/RST with the file.

---
 rtl/rf_access_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: initiator-side sequencer for the 32x32 dual-read register file.
// Turns single-cycle host requests (operand fetch, writeback) into the file's
// READ/WRITE handshake and captures both read ports into stable operand registers.
// Optional feature macro: RF_ZERO_REG_EN (register 0 hardwired to zero).
module rf_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RD_REQ,
    input  logic                  WR_REQ,
    input  logic [ADDR_WIDTH-1:0] RS,
    input  logic [ADDR_WIDTH-1:0] RT,
    input  logic [ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    output logic                  BUSY,
    output logic                  OP_VALID,
    output logic [DATA_WIDTH-1:0] OP1,
    output logic [DATA_WIDTH-1:0] OP2,
    output logic                  WR_DONE,
    output logic                  RF_READ,
    output logic                  RF_WRITE,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
    output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
    output logic [DATA_WIDTH-1:0] RF_DATA_W,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
    input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WR_ISSUE   = 2'd1,
        S_RD_ISSUE   = 2'd2,
        S_RD_CAPTURE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA = {DATA_WIDTH{1'b0}};

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_pend;
    logic                  w_pend_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_op_valid;
    logic                  w_op_valid_next;
    logic                  r_wr_done;
    logic                  w_wr_done_next;
    logic                  r_rf_read;
    logic                  w_rf_read_next;
    logic                  r_rf_write;
    logic                  w_rf_write_next;
    logic [DATA_WIDTH-1:0] r_op1;
    logic [DATA_WIDTH-1:0] w_op1_next;
    logic [DATA_WIDTH-1:0] r_op2;
    logic [DATA_WIDTH-1:0] w_op2_next;
    logic [ADDR_WIDTH-1:0] r_addr_r1;
    logic [ADDR_WIDTH-1:0] w_addr_r1_next;
    logic [ADDR_WIDTH-1:0] r_addr_r2;
    logic [ADDR_WIDTH-1:0] w_addr_r2_next;
    logic [ADDR_WIDTH-1:0] r_addr_w;
    logic [ADDR_WIDTH-1:0] w_addr_w_next;
    logic [DATA_WIDTH-1:0] r_data_w;
    logic [DATA_WIDTH-1:0] w_data_w_next;

    // Whether an accepted write actually reaches the file, and what a capture
    // stores; register 0 is forced to zero only when the feature is built in.
    logic                  w_wr_effective;
    logic [DATA_WIDTH-1:0] w_op1_cap;
    logic [DATA_WIDTH-1:0] w_op2_cap;

`ifdef RF_ZERO_REG_EN
    assign w_wr_effective = (RD_ADDR != ZERO_ADDR);
    assign w_op1_cap      = (r_addr_r1 == ZERO_ADDR) ? ZERO_DATA : RF_DATA_R1;
    assign w_op2_cap      = (r_addr_r2 == ZERO_ADDR) ? ZERO_DATA : RF_DATA_R2;
`else
    assign w_wr_effective = 1'b1;
    assign w_op1_cap      = RF_DATA_R1;
    assign w_op2_cap      = RF_DATA_R2;
`endif

    // Next-state, request sampling and registered-output decode.
    always_comb begin
        w_state_next    = r_state;
        w_pend_next     = r_pend;
        w_op_valid_next = 1'b0;
        w_wr_done_next  = 1'b0;
        w_rf_write_next = 1'b0;
        w_op1_next      = r_op1;
        w_op2_next      = r_op2;
        w_addr_r1_next  = r_addr_r1;
        w_addr_r2_next  = r_addr_r2;
        w_addr_w_next   = r_addr_w;
        w_data_w_next   = r_data_w;

        case (r_state)
            S_IDLE: begin
                // A write always goes first; a simultaneous read waits behind it.
                if (WR_REQ) begin
                    w_state_next    = S_WR_ISSUE;
                    w_pend_next     = RD_REQ;
                    w_rf_write_next = w_wr_effective;
                end else if (RD_REQ) begin
                    w_state_next = S_RD_ISSUE;
                    w_pend_next  = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                end
                if (WR_REQ || RD_REQ) begin
                    w_addr_r1_next = RS;
                    w_addr_r2_next = RT;
                    w_addr_w_next  = RD_ADDR;
                    w_data_w_next  = WR_DATA;
                end else begin
                    w_addr_r1_next = r_addr_r1;
                    w_addr_r2_next = r_addr_r2;
                    w_addr_w_next  = r_addr_w;
                    w_data_w_next  = r_data_w;
                end
            end
            S_WR_ISSUE: begin
                w_wr_done_next = 1'b1;
                if (r_pend) begin
                    w_state_next = S_RD_ISSUE;
                    w_pend_next  = 1'b0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                w_state_next = S_RD_CAPTURE;
            end
            S_RD_CAPTURE: begin
                w_state_next    = S_IDLE;
                w_op_valid_next = 1'b1;
                w_op1_next      = w_op1_cap;
                w_op2_next      = w_op2_cap;
            end
            default: begin
                w_state_next = S_IDLE;
                w_pend_next  = 1'b0;
            end
        endcase

        // READ is a pure function of the upcoming state, so it can never
        // coincide with WRITE (which is only set on entry to WR_ISSUE).
        w_busy_next    = (w_state_next != S_IDLE);
        w_rf_read_next = (w_state_next == S_RD_ISSUE) || (w_state_next == S_RD_CAPTURE);
    end

    // State and output registers; reset aborts any operation without a pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_pend     <= 1'b0;
            r_busy     <= 1'b0;
            r_op_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rf_read  <= 1'b0;
            r_rf_write <= 1'b0;
            r_op1      <= ZERO_DATA;
            r_op2      <= ZERO_DATA;
            r_addr_r1  <= ZERO_ADDR;
            r_addr_r2  <= ZERO_ADDR;
            r_addr_w   <= ZERO_ADDR;
            r_data_w   <= ZERO_DATA;
        end else begin
            r_state    <= w_state_next;
            r_pend     <= w_pend_next;
            r_busy     <= w_busy_next;
            r_op_valid <= w_op_valid_next;
            r_wr_done  <= w_wr_done_next;
            r_rf_read  <= w_rf_read_next;
            r_rf_write <= w_rf_write_next;
            r_op1      <= w_op1_next;
            r_op2      <= w_op2_next;
            r_addr_r1  <= w_addr_r1_next;
            r_addr_r2  <= w_addr_r2_next;
            r_addr_w   <= w_addr_w_next;
            r_data_w   <= w_data_w_next;
        end
    end

    assign BUSY       = r_busy;
    assign OP_VALID   = r_op_valid;
    assign OP1        = r_op1;
    assign OP2        = r_op2;
    assign WR_DONE    = r_wr_done;
    assign RF_READ    = r_rf_read;
    assign RF_WRITE   = r_rf_write;
    assign RF_ADDR_R1 = r_addr_r1;
    assign RF_ADDR_R2 = r_addr_r2;
    assign RF_ADDR_W  = r_addr_w;
    assign RF_DATA_W  = r_data_w;

endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed + random bench for rf_access_ctrl with a
// behavioural 32x32 register file and a cycle-stamped scoreboard.
// Honours RF_ZERO_REG_EN when the design is built with it.
module tb_rf_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RD_REQ, WR_REQ;
    logic [AW-1:0] RS, RT, RD_ADDR;
    logic [DW-1:0] WR_DATA;
    logic          BUSY, OP_VALID, WR_DONE, RF_READ, RF_WRITE;
    logic [DW-1:0] OP1, OP2, RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
    logic [AW-1:0] RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;

    always #5 CLK = ~CLK;

    rf_access_ctrl dut (
        .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .WR_REQ(WR_REQ),
        .RS(RS), .RT(RT), .RD_ADDR(RD_ADDR), .WR_DATA(WR_DATA),
        .BUSY(BUSY), .OP_VALID(OP_VALID), .OP1(OP1), .OP2(OP2), .WR_DONE(WR_DONE),
        .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
        .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
        .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
    );

    function automatic logic [31:0] init_val(input int i);
        logic [31:0] v;
        v = 32'h01000193 * i;
`ifdef RF_ZERO_REG_EN
        if (i == 0) v = 32'hBAD0BAD0;
`endif
        return v;
    endfunction

    // Register file model: writes and read-latches on the clock edge.
    logic [DW-1:0] fmem [32];
    bit            fmem_ready = 1'b0;
    always @(posedge CLK) begin
        if (!fmem_ready) begin
            for (int i = 0; i < 32; i++) fmem[i] <= init_val(i);
            fmem_ready <= 1'b1;
            RF_DATA_R1 <= 32'd0;
            RF_DATA_R2 <= 32'd0;
        end else begin
            if (RF_WRITE === 1'b1) fmem[RF_ADDR_W] <= RF_DATA_W;
            if (RF_READ === 1'b1) begin
                RF_DATA_R1 <= fmem[RF_ADDR_R1];
                RF_DATA_R2 <= fmem[RF_ADDR_R2];
            end
        end
    end

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        int          cyc;
    } rd_exp_t;

    rd_exp_t     rdq[$];
    int          wrq[$];
    logic [31:0] ref_regs [32];
    int          n_vec  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          rd_run = 0;

    function automatic bit wr_effective(input logic [4:0] a);
`ifdef RF_ZERO_REG_EN
        return (a != 5'd0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
`ifdef RF_ZERO_REG_EN
        if (a == 5'd0) return 32'd0;
`endif
        return ref_regs[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: sample on the falling edge, run protocol checks and the scoreboard.
    task automatic tick();
        rd_exp_t e;
        int      wc;
        @(negedge CLK);
        cyc++;
        if (RST !== 1'b1) begin
            rd_run = 0;
        end else begin
            check("rd_wr_exclusive", 32'(RF_READ & RF_WRITE), 32'd0);
            if (RF_READ === 1'b1) rd_run++;
            else if (rd_run != 0) begin
                check("rd_run_len", 32'(rd_run), 32'd2);
                rd_run = 0;
            end
            if (OP_VALID === 1'b1) begin
                if (rdq.size() == 0) check("op_valid_unexpected", 32'(OP_VALID), 32'd0);
                else begin
                    e = rdq.pop_front();
                    check("op_valid_cycle", 32'(cyc), 32'(e.cyc));
                    check("op1", OP1, e.op1);
                    check("op2", OP2, e.op2);
                end
            end
            if (WR_DONE === 1'b1) begin
                if (wrq.size() == 0) check("wr_done_unexpected", 32'(WR_DONE), 32'd0);
                else begin
                    wc = wrq.pop_front();
                    check("wr_done_cycle", 32'(cyc), 32'(wc));
                end
            end
        end
    endtask

    // Drive one request while idle, record expectations, consume the sampling edge.
    task automatic issue(input logic rd, input logic wr, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rda, input logic [31:0] d);
        rd_exp_t e;
        int      c;
        c = cyc;
        if (wr) begin
            wrq.push_back(c + 2);
            if (wr_effective(rda)) ref_regs[rda] = d;
        end
        if (rd) begin
            e.op1 = exp_rd(rs);
            e.op2 = exp_rd(rt);
            e.cyc = c + (wr ? 4 : 3);
            rdq.push_back(e);
        end
        RD_REQ = rd; WR_REQ = wr; RS = rs; RT = rt; RD_ADDR = rda; WR_DATA = d;
        tick();
        RD_REQ = 1'b0; WR_REQ = 1'b0;
        if (rd || wr) check("busy_after_req", 32'(BUSY), 32'd1);
    endtask

    // Wait (bounded) for BUSY to drop, optionally throwing ignored requests meanwhile.
    task automatic wait_idle(input bit junk);
        int k;
        k = 0;
        while (BUSY !== 1'b0 && k < 8) begin
            if (junk) begin
                RD_REQ  = 1'($urandom_range(0, 1));
                WR_REQ  = 1'($urandom_range(0, 1));
                RS      = 5'($urandom_range(0, 31));
                RT      = 5'($urandom_range(0, 31));
                RD_ADDR = 5'($urandom_range(0, 31));
                WR_DATA = $urandom;
            end
            tick();
            k++;
        end
        RD_REQ = 1'b0; WR_REQ = 1'b0;
        check("idle_reached", 32'(BUSY), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(BUSY),       32'd0);
        check({tag, "_op_valid"}, 32'(OP_VALID),   32'd0);
        check({tag, "_wr_done"},  32'(WR_DONE),    32'd0);
        check({tag, "_rf_read"},  32'(RF_READ),    32'd0);
        check({tag, "_rf_write"}, 32'(RF_WRITE),   32'd0);
        check({tag, "_op1"},      OP1,             32'd0);
        check({tag, "_op2"},      OP2,             32'd0);
        check({tag, "_addr_r1"},  32'(RF_ADDR_R1), 32'd0);
        check({tag, "_addr_r2"},  32'(RF_ADDR_R2), 32'd0);
        check({tag, "_addr_w"},   32'(RF_ADDR_W),  32'd0);
        check({tag, "_data_w"},   RF_DATA_W,       32'd0);
    endtask

    initial begin
        int kind;
        for (int i = 0; i < 32; i++) ref_regs[i] = init_val(i);
        RST = 1'b1; RD_REQ = 1'b0; WR_REQ = 1'b0;
        RS = 5'd0; RT = 5'd0; RD_ADDR = 5'd0; WR_DATA = 32'd0;
        #1 RST = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        RST = 1'b1;
        tick();

        // Write 0xDEADBEEF to r5, then read r5/r0 back-to-back.
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
        check("wr_issue_rf_write", 32'(RF_WRITE), 32'd1);
        check("wr_issue_addr_w", 32'(RF_ADDR_W), 32'd5);
        check("wr_issue_data_w", RF_DATA_W, 32'hDEADBEEF);
        wait_idle(1'b0);
        issue(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, 32'd0);
        wait_idle(1'b0);
        check("op1_deadbeef", OP1, 32'hDEADBEEF);
        check("op2_zero", OP2, 32'h00000000);

        // Simultaneous read and write of r7: write first, read sees new data.
        issue(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'h12345678);
        check("sim_wr_issue", 32'(RF_WRITE), 32'd1);
        check("sim_wr_issue_rd", 32'(RF_READ), 32'd0);
        tick();
        check("sim_rd_issue", 32'(RF_READ), 32'd1);
        tick();
        check("sim_rd_capture", 32'(RF_READ), 32'd1);
        wait_idle(1'b0);
        check("sim_op1", OP1, 32'h12345678);

        // Write to r3 while busy must be dropped.
        issue(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0);
        WR_REQ = 1'b1; RD_ADDR = 5'd3; WR_DATA = 32'h00000001;
        tick();
        WR_REQ = 1'b0;
        wait_idle(1'b0);
        issue(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'd0);
        wait_idle(1'b0);
        check("busy_ignore_r3", OP1, init_val(3));

        // Reset in the middle of RD_CAPTURE aborts without a pulse.
        issue(1'b1, 1'b0, 5'd9, 5'd10, 5'd0, 32'd0);
        tick();
        check("pre_reset_rd_capture", 32'(RF_READ), 32'd1);
        #2 RST = 1'b0;
        #1 check_all_zero("midreset");
        rdq.delete();
        wrq.delete();
        tick();
        check("midreset_no_op_valid", 32'(OP_VALID), 32'd0);
        RST = 1'b1;
        tick();
        issue(1'b1, 1'b0, 5'd9, 5'd10, 5'd0, 32'd0);
        wait_idle(1'b0);

        // Reset during WR_ISSUE must also drop the pending read.
        issue(1'b1, 1'b1, 5'd11, 5'd11, 5'd11, 32'hCAFEF00D);
        #2 RST = 1'b0;
        rdq.delete();
        wrq.delete();
        fork begin #1; end join
        tick();
        RST = 1'b1;
        ref_regs[11] = init_val(11);
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd12, 32'h0BADBEEF);
        wait_idle(1'b0);
        repeat (4) tick();

`ifdef RF_ZERO_REG_EN
        issue(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
        check("zero_wr_rf_write", 32'(RF_WRITE), 32'd0);
        wait_idle(1'b0);
        issue(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
        wait_idle(1'b0);
        check("zero_rd_op1", OP1, 32'd0);
`endif

        // Random requests with ignored traffic while busy.
        for (int n = 0; n < 1000; n++) begin
            kind = $urandom_range(0, 2);
            issue(1'(kind != 1), 1'(kind != 0), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
            wait_idle(1'b1);
        end

        repeat (4) tick();
        check("rd_queue_drained", 32'(rdq.size()), 32'd0);
        check("wr_queue_drained", 32'(wrq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end
endmodule
